// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Drives one external Montgomery multiplier over a start/done handshake.
module mont_exp_ctrl #(
    parameter int N       = 512,
    parameter int E_WIDTH = 512,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [N-1:0]       in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [N-1:0]       in_m,
    input  logic [N-1:0]       in_r,
    input  logic [N-1:0]       in_r2,
    output logic [N-1:0]       result,
    output logic               done,
    output logic               busy,
    output logic [CW-1:0]      mm_count,
    output logic               mm_start,
    output logic [N-1:0]       mm_a,
    output logic [N-1:0]       mm_b,
    output logic [N-1:0]       mm_m,
    input  logic [N-1:0]       mm_result,
    input  logic               mm_done
);

    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISS_TOM,
        S_W_TOM,
        S_ISS_SQ,
        S_W_SQ,
        S_ISS_MUL,
        S_W_MUL,
        S_ISS_FROM,
        S_W_FROM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic [N-1:0]       m_q, m_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       xm_q, xm_d;
    logic [IW-1:0]      i_q, i_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       res_q, res_d;
    logic [N-1:0]       opa_q, opa_d;
    logic [N-1:0]       opb_q, opb_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            e_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            xm_q    <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            m_q     <= m_d;
            a_q     <= a_d;
            xm_q    <= xm_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Operands are loaded on the edge entering an ISS state and then held
    // untouched until the matching mm_done, so the multiplier sees stable inputs.
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        m_d     = m_q;
        a_d     = a_q;
        xm_d    = xm_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISS_TOM;
                    e_d     = in_e;
                    m_d     = in_m;
                    a_d     = in_r;
                    i_d     = IW'(E_WIDTH - 1);
                    cnt_d   = '0;
                    opa_d   = in_x;
                    opb_d   = in_r2;
                end
            end
            S_ISS_TOM: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_W_TOM;
            end
            S_ISS_SQ: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_W_SQ;
            end
            S_ISS_MUL: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_W_MUL;
            end
            S_ISS_FROM: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_W_FROM;
            end
            S_W_TOM: begin
                if (mm_done) begin
                    xm_d    = mm_result;
                    state_d = S_ISS_SQ;
                    opa_d   = a_q;
                    opb_d   = a_q;
                end
            end
            S_W_SQ: begin
                if (mm_done) begin
                    a_d   = mm_result;
                    opa_d = mm_result;
                    if (e_q[i_q]) begin
                        state_d = S_ISS_MUL;
                        opb_d   = xm_q;
                    end else if (i_q == '0) begin
                        state_d = S_ISS_FROM;
                        opb_d   = N'(1);
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = S_ISS_SQ;
                        opb_d   = mm_result;
                    end
                end
            end
            S_W_MUL: begin
                if (mm_done) begin
                    a_d   = mm_result;
                    opa_d = mm_result;
                    if (i_q == '0) begin
                        state_d = S_ISS_FROM;
                        opb_d   = N'(1);
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = S_ISS_SQ;
                        opb_d   = mm_result;
                    end
                end
            end
            S_W_FROM: begin
                if (mm_done) begin
                    res_d   = mm_result;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign result   = res_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign mm_count = cnt_q;
    assign mm_start = (state_q == S_ISS_TOM) || (state_q == S_ISS_SQ) ||
                      (state_q == S_ISS_MUL) || (state_q == S_ISS_FROM);
    assign mm_a     = opa_q;
    assign mm_b     = opb_q;
    assign mm_m     = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier (m=13, R^-1=3)
// plus vector table, reset/spurious-event sequences and random operations.
module tb_mont_exp_ctrl;

    localparam int N    = 512;
    localparam int EW   = 16;
    localparam int CW   = 16;
    localparam int MOD  = 13;
    localparam int RV   = 9;
    localparam int R2V  = 3;
    localparam int RINV = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [N-1:0]  in_x, in_m, in_r, in_r2;
    logic [EW-1:0] in_e;
    logic [N-1:0]  result;
    logic          done, busy;
    logic [CW-1:0] mm_count;
    logic          mm_start;
    logic [N-1:0]  mm_a, mm_b, mm_m;
    logic [N-1:0]  mm_result;
    logic          mm_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mont_exp_ctrl #(.N(N), .E_WIDTH(EW), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy), .mm_count(mm_count),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mont(input int a, input int b);
        return (a * b * RINV) % MOD;
    endfunction

    function automatic int modpow(input int x, input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = (r * x) % MOD;
        return r;
    endfunction

    function automatic int popc(input logic [EW-1:0] e);
        int c = 0;
        for (int k = 0; k < EW; k++) c += int'(e[k]);
        return c;
    endfunction

    // Multiplier model: latency L cycles from mm_start to mm_done
    bit            rand_lat    = 1'b0;
    bit            inject_spur = 1'b0;
    int            n_iss       = 0;
    bit            pend        = 1'b0;
    int            left        = 0;
    logic [N-1:0]  cap_a, cap_b;

    initial begin
        mm_done   = 1'b0;
        mm_result = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("mm_a_stable", mm_a, cap_a);
                check("mm_b_stable", mm_b, cap_b);
                left--;
                if (left == 0) begin
                    pend      = 1'b0;
                    mm_done   = 1'b1;
                    mm_result = N'(mont(int'(cap_a[7:0]), int'(cap_b[7:0])));
                end
            end
            if (mm_start) begin
                check("mm_count_at_issue", mm_count, N'(n_iss));
                check("mm_m", mm_m, in_m);
                pend  = 1'b1;
                left  = rand_lat ? int'($urandom_range(1, 20)) : 5;
                cap_a = mm_a;
                cap_b = mm_b;
                if (inject_spur && n_iss == 1) begin
                    mm_done     = 1'b1;
                    mm_result   = N'(4);
                    inject_spur = 1'b0;
                end
                n_iss++;
            end
        end
    end

    task automatic chk_reset(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mm_start"}, mm_start, 0);
        check({tag, "_mm_count"}, mm_count, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_mm_a"}, mm_a, 0);
        check({tag, "_mm_b"}, mm_b, 0);
        check({tag, "_mm_m"}, mm_m, 0);
    endtask

    task automatic run_op(input int x, input logic [EW-1:0] e, input bit rl,
                          input bit inj_start, input int exp_res,
                          input int exp_cnt);
        int c0, k, pulses;
        in_x     = N'(x);
        in_e     = e;
        n_iss    = 0;
        rand_lat = rl;
        start    = 1'b1;
        c0       = cyc;
        @(negedge clk);
        start = 1'b0;
        in_x  = N'(7);
        in_e  = '0;
        check("busy_after_start", busy, 1);
        k = 0;
        while (!done && k < 5000) begin
            start = inj_start && ((cyc - c0) == 30);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (!rl) check("done_cycle", N'(cyc - c0), N'(1 + exp_cnt * 6));
        check("result", result, N'(exp_res));
        check("mm_count", mm_count, N'(exp_cnt));
        check("busy_in_done", busy, 1);
        pulses = 1;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("done_pulses", N'(pulses), 1);
        check("busy_idle", busy, 0);
        check("result_held", result, N'(exp_res));
        check("mm_count_held", mm_count, N'(exp_cnt));
    endtask

    typedef struct {
        int            x;
        logic [EW-1:0] e;
        bit            rl;
        bit            inj_start;
        bit            inj_spur;
        int            exp_res;
        int            exp_cnt;
    } vec_t;

    vec_t tv[5];

    initial begin
        tv[0] = '{5, 16'h0003, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[1] = '{7, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[2] = '{2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[3] = '{5, 16'h0003, 1'b0, 1'b1, 1'b1, 0, 0};
        tv[4] = '{11, 16'h0A35, 1'b1, 1'b0, 1'b0, 0, 0};
        foreach (tv[j]) begin
            tv[j].exp_res = modpow(tv[j].x, int'(tv[j].e));
            tv[j].exp_cnt = EW + popc(tv[j].e) + 2;
        end

        resetn = 1'b0;
        start  = 1'b0;
        in_x   = '0;
        in_e   = '0;
        in_m   = N'(MOD);
        in_r   = N'(RV);
        in_r2  = N'(R2V);
        repeat (2) @(negedge clk);
        chk_reset("reset");
        resetn = 1'b1;
        @(negedge clk);

        for (int j = 0; j < 5; j++) begin
            inject_spur = tv[j].inj_spur;
            run_op(tv[j].x, tv[j].e, tv[j].rl, tv[j].inj_start,
                   tv[j].exp_res, tv[j].exp_cnt);
        end

        in_x  = N'(5);
        in_e  = 16'h0003;
        n_iss = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_before_reset", busy, 1);
        resetn = 1'b0;
        #1;
        chk_reset("async_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op(5, 16'h0003, 1'b0, 1'b0, modpow(5, 3), EW + popc(16'h0003) + 2);

        for (int j = 0; j < 4; j++) begin
            int            rx;
            logic [EW-1:0] re;
            rx = int'($urandom_range(1, MOD - 1));
            re = EW'($urandom);
            run_op(rx, re, 1'b1, 1'b0, modpow(rx, int'(re)), EW + popc(re) + 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
